// File: rtl/hdmi_reset_seq_if.sv
// HDMI reset sequencer signal bundle: the PLL lock input plus the staged
// reset outputs and status that the sequencer drives.
interface hdmi_reset_seq_if;
   logic       pll_lock;
   logic       pll_reset;
   logic       serdes_rst;
   logic       pix_rst;
   logic       ready;
   logic [3:0] retry_cnt;

   // Sequencer side: watches the lock, drives the resets and status
   modport master (
      input  pll_lock,
      output pll_reset,
      output serdes_rst,
      output pix_rst,
      output ready,
      output retry_cnt
   );

   // Consumer side: provides the lock, observes the resets and status
   modport slave (
      output pll_lock,
      input  pll_reset,
      input  serdes_rst,
      input  pix_rst,
      input  ready,
      input  retry_cnt
   );
endinterface

// File: rtl/hdmi_reset_seq.sv
// HDMI reset sequencer: pulses the TMDS rPLL reset, waits for a stable lock,
// then releases the serializer reset followed by the pixel reset. Lock loss
// drops back to waiting for lock; timeouts re-pulse the PLL and count retries.
module hdmi_reset_seq #(
   parameter int unsigned PLL_RST_CYC      = 16,
   parameter int unsigned LOCK_TIMEOUT_CYC = 65535,
   parameter int unsigned LOCK_STABLE_CYC  = 1024,
   parameter int unsigned STAGE_GAP_CYC    = 8
) (
   input logic               clk,
   input logic               rst,
   hdmi_reset_seq_if.master  hdmi
);

   localparam int unsigned MAX_AB  = (PLL_RST_CYC > LOCK_TIMEOUT_CYC) ? PLL_RST_CYC : LOCK_TIMEOUT_CYC;
   localparam int unsigned MAX_CD  = (LOCK_STABLE_CYC > STAGE_GAP_CYC) ? LOCK_STABLE_CYC : STAGE_GAP_CYC;
   localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int          CNT_W   = $clog2(MAX_CYC + 1);

   // Terminal counts: each state leaves on the last cycle of its window
   localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYC - 1);

   typedef enum logic [2:0] {
      S_PLLRST,
      S_WAIT_LOCK,
      S_STABLE,
      S_SER_REL,
      S_PIX_REL,
      S_RUN
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [3:0]       retry, retry_nx;
   logic             lock_meta, lock_s;
   logic             pll_reset_q, serdes_rst_q, pix_rst_q, ready_q;

   // Two-flop synchronizer bringing the asynchronous PLL lock into clk
   // NOTE: non-blocking assignments make both flops sample the old values
   // at the same edge; blocking here would collapse the chain to one flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= hdmi.pll_lock;
         lock_s    <= lock_meta;
      end
   end

   // Next-state, counter and retry decisions
   // NOTE: every variable gets a default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 1'b1;
      retry_nx = retry;
      unique case (state)
         S_PLLRST: begin
            if (cnt == PLL_RST_LAST) begin
               state_nx = S_WAIT_LOCK;
               cnt_nx   = '0;
            end
         end
         S_WAIT_LOCK: begin
            if (lock_s) begin
               state_nx = S_STABLE;
               cnt_nx   = '0;
            end else if (cnt == TIMEOUT_LAST) begin
               state_nx = S_PLLRST;
               cnt_nx   = '0;
               if (retry != 4'hF) retry_nx = retry + 4'd1;
            end
         end
         S_STABLE: begin
            if (!lock_s) begin
               state_nx = S_WAIT_LOCK;
               cnt_nx   = '0;
            end else if (cnt == STABLE_LAST) begin
               state_nx = S_SER_REL;
               cnt_nx   = '0;
            end
         end
         S_SER_REL: begin
            if (!lock_s) begin
               state_nx = S_WAIT_LOCK;
               cnt_nx   = '0;
            end else if (cnt == GAP_LAST) begin
               state_nx = S_PIX_REL;
               cnt_nx   = '0;
            end
         end
         S_PIX_REL: begin
            if (!lock_s) begin
               state_nx = S_WAIT_LOCK;
               cnt_nx   = '0;
            end else if (cnt == GAP_LAST) begin
               state_nx = S_RUN;
               cnt_nx   = '0;
            end
         end
         S_RUN: begin
            cnt_nx = '0;
            if (!lock_s) state_nx = S_WAIT_LOCK;
         end
         default: begin
            state_nx = S_PLLRST;
            cnt_nx   = '0;
         end
      endcase
   end

   // State, counter, retry count and outputs; outputs are decoded from the
   // next state so each flop already shows the level of the state entered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_PLLRST;
         cnt          <= '0;
         retry        <= '0;
         pll_reset_q  <= 1'b1;
         serdes_rst_q <= 1'b1;
         pix_rst_q    <= 1'b1;
         ready_q      <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         retry        <= retry_nx;
         pll_reset_q  <= (state_nx == S_PLLRST);
         serdes_rst_q <= (state_nx == S_PLLRST) || (state_nx == S_WAIT_LOCK) ||
                         (state_nx == S_STABLE);
         pix_rst_q    <= (state_nx != S_PIX_REL) && (state_nx != S_RUN);
         ready_q      <= (state_nx == S_RUN);
      end
   end

   assign hdmi.pll_reset  = pll_reset_q;
   assign hdmi.serdes_rst = serdes_rst_q;
   assign hdmi.pix_rst    = pix_rst_q;
   assign hdmi.ready      = ready_q;
   assign hdmi.retry_cnt  = retry;

endmodule

// File: tb/tb_hdmi_reset_seq.sv
// Bench for the HDMI reset sequencer: directed bring-up, timeout, glitch,
// lock-loss and async-reset scenarios followed by random lock traffic, all
// compared each cycle against a phase/time-remaining reference model.
module tb_hdmi_reset_seq;

   localparam int PLL_RST_CYC      = 4;
   localparam int LOCK_TIMEOUT_CYC = 50;
   localparam int LOCK_STABLE_CYC  = 8;
   localparam int STAGE_GAP_CYC    = 3;

   localparam int P_PLLRST = 0;
   localparam int P_WAIT   = 1;
   localparam int P_STABLE = 2;
   localparam int P_SER    = 3;
   localparam int P_PIX    = 4;
   localparam int P_RUN    = 5;

   logic clk;
   logic rst;

   hdmi_reset_seq_if bus ();

   hdmi_reset_seq #(
      .PLL_RST_CYC      (PLL_RST_CYC),
      .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
      .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
      .STAGE_GAP_CYC    (STAGE_GAP_CYC)
   ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .hdmi (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: current phase, cycles left in it, retries, and the
   // two-cycle lock delay line
   int ph;
   int left;
   int retries;
   bit hist[$];

   // Observed-output edge tracking
   bit prev_pll = 1'b1, prev_ser = 1'b1, prev_pix = 1'b1, prev_rdy = 1'b0;
   int last_pll_fall = -1, last_ser_fall = -1, last_pix_fall = -1, last_rdy_rise = -1;
   int pll_rises = 0, pll_run = 0, last_pll_width = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      ph      = P_PLLRST;
      left    = PLL_RST_CYC;
      retries = 0;
      hist    = {1'b0, 1'b0};
   endfunction

   function automatic void model_step(input bit lk);
      bit ls;
      ls = hist.pop_front();
      hist.push_back(lk);
      case (ph)
         P_PLLRST: begin
            left--;
            if (left == 0) begin ph = P_WAIT; left = LOCK_TIMEOUT_CYC; end
         end
         P_WAIT: begin
            if (ls) begin
               ph = P_STABLE; left = LOCK_STABLE_CYC;
            end else begin
               left--;
               if (left == 0) begin
                  ph = P_PLLRST; left = PLL_RST_CYC;
                  if (retries < 15) retries++;
               end
            end
         end
         P_STABLE, P_SER, P_PIX: begin
            if (!ls) begin
               ph = P_WAIT; left = LOCK_TIMEOUT_CYC;
            end else begin
               left--;
               if (left == 0) begin
                  if (ph == P_STABLE) begin ph = P_SER; left = STAGE_GAP_CYC; end
                  else if (ph == P_SER) begin ph = P_PIX; left = STAGE_GAP_CYC; end
                  else ph = P_RUN;
               end
            end
         end
         default: begin
            if (!ls) begin ph = P_WAIT; left = LOCK_TIMEOUT_CYC; end
         end
      endcase
   endfunction

   function automatic logic [7:0] model_pack();
      bit m_pll, m_ser, m_pix, m_rdy;
      m_pll = (ph == P_PLLRST);
      m_ser = (ph == P_PLLRST) || (ph == P_WAIT) || (ph == P_STABLE);
      m_pix = m_ser || (ph == P_SER);
      m_rdy = (ph == P_RUN);
      return {m_pll, m_ser, m_pix, m_rdy, 4'(retries)};
   endfunction

   function automatic logic [7:0] dut_pack();
      return {bus.pll_reset, bus.serdes_rst, bus.pix_rst, bus.ready, bus.retry_cnt};
   endfunction

   // One clock: drive lock from the falling edge, let the model take the
   // rising edge, compare on the next falling edge
   task automatic tick(input bit lk);
      bus.pll_lock = lk;
      @(posedge clk);
      if (rst) model_reset();
      else     model_step(lk);
      @(negedge clk);
      cyc++;
      check("outputs", 32'(dut_pack()), 32'(model_pack()));
      if (bus.pll_reset) begin
         if (!prev_pll) pll_rises++;
         pll_run++;
      end else begin
         if (prev_pll) begin last_pll_fall = cyc; last_pll_width = pll_run; end
         pll_run = 0;
      end
      if (prev_ser && !bus.serdes_rst) last_ser_fall = cyc;
      if (prev_pix && !bus.pix_rst)    last_pix_fall = cyc;
      if (!prev_rdy && bus.ready)      last_rdy_rise = cyc;
      prev_pll = bus.pll_reset;
      prev_ser = bus.serdes_rst;
      prev_pix = bus.pix_rst;
      prev_rdy = bus.ready;
   endtask

   task automatic run(input bit lk, input int n);
      for (int i = 0; i < n; i++) tick(lk);
   endtask

   // Hold reset across a few edges, release it on a falling edge
   task automatic do_reset();
      rst = 1'b1;
      run(1'b0, 3);
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      bus.pll_lock = 1'b0;
      rst = 1'b0;
      model_reset();
      #1 rst = 1'b1;
      #1 check("reset_async_init", 32'(dut_pack()), 32'h0000_00E0);
      @(negedge clk);
      run(1'b0, 3);
      check("reset_values", 32'(dut_pack()), 32'h0000_00E0);

      // Clean bring-up: lock sampled high from the 10th edge after release
      rst  = 1'b0;
      base = cyc;
      for (int i = 1; i <= 40; i++) tick(i >= 10);
      check("bringup_pll_fall", 32'(last_pll_fall - base), 32'd4);
      check("bringup_ser_fall", 32'(last_ser_fall - base), 32'd20);
      check("bringup_pix_fall", 32'(last_pix_fall - base), 32'd23);
      check("bringup_rdy_rise", 32'(last_rdy_rise - base), 32'd26);
      check("bringup_retry",    32'(bus.retry_cnt), 32'd0);

      // Lock loss in RUN: one low cycle, outputs fall back within 3 clocks
      base = cyc;
      tick(1'b0);
      tick(1'b1);
      tick(1'b1);
      check("lockloss_resets", 32'({bus.pll_reset, bus.serdes_rst, bus.pix_rst, bus.ready}), 32'b0110);
      run(1'b1, 20);
      check("relock_ser_fall", 32'(last_ser_fall - base), 32'd12);
      check("relock_pix_fall", 32'(last_pix_fall - base), 32'd15);
      check("relock_rdy_rise", 32'(last_rdy_rise - base), 32'd18);

      // No lock for 500 cycles: 4-wide pll_reset pulses every 54 cycles
      do_reset();
      base = pll_rises;
      run(1'b0, 500);
      check("nolock_retry",  32'(bus.retry_cnt), 32'd9);
      check("nolock_pulses", 32'(pll_rises - base), 32'd9);
      check("nolock_width",  32'(last_pll_width), 32'd4);

      // Twenty more timeouts: retry count saturates
      run(1'b0, 20 * (PLL_RST_CYC + LOCK_TIMEOUT_CYC));
      check("saturate_retry", 32'(bus.retry_cnt), 32'd15);

      // Stability filter: 5 high, 1 low, then high
      do_reset();
      base = cyc;
      run(1'b0, 10);
      run(1'b1, 5);
      tick(1'b0);
      run(1'b1, 15);
      check("glitch_ser_fall", 32'(last_ser_fall - base), 32'd27);
      check("glitch_in_pix",   32'({bus.serdes_rst, bus.pix_rst, bus.ready}), 32'b000);

      // Async reset while pixel reset is released, between clock edges
      bus.pll_lock = 1'b1;
      @(posedge clk);
      model_step(1'b1);
      #2 rst = 1'b1;
      #1 check("async_rst_pix", 32'(dut_pack()), 32'h0000_00E0);
      model_reset();
      @(negedge clk);
      cyc++;
      run(1'b1, 2);
      rst = 1'b0;
      run(1'b1, 30);
      check("after_async_ready", 32'(bus.ready), 32'd1);

      // Random lock traffic with occasional reset pulses
      for (int s = 0; s < 60; s++) begin
         bit lvl;
         int len;
         lvl = ($urandom_range(0, 3) != 0);
         len = lvl ? $urandom_range(1, 40) : $urandom_range(1, 6);
         if ($urandom_range(0, 9) == 0) len = $urandom_range(50, 70);
         if ($urandom_range(0, 14) == 0) begin
            rst = 1'b1;
            run(lvl, $urandom_range(1, 2));
            rst = 1'b0;
         end
         run(lvl, len);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
